// File: rtl/vscale_lsu_pkg.sv
// Shared definitions for the vscale load/store unit.
//   size_e        : access size encodings (byte/half/word/double)
//   state_e       : LSU sequencer states
//   crosses_beat  : true when an access starting at byte offset `off` of
//                   size `size` runs past the end of an `nb`-byte bus beat
package vscale_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic crosses_beat(input int unsigned off,
                                        input logic [1:0]  size,
                                        input int unsigned nb);
    return (off + (32'd1 << size)) > nb;
  endfunction

endpackage

// File: rtl/vscale_lsu_align.sv
// Combinational lane alignment for the LSU.
//   beat        : beat index (0 = first, 1 = second of a crossing access)
//   off, size   : byte offset within the beat and access size
//   is_unsigned : zero-extend instead of sign-extend loads
//   wdata       : right-justified store data
//   ld_buf      : captured load data, {beat1, beat0}
//   beat_be     : byte enables for the selected beat
//   beat_wdata  : lane-aligned store data for the selected beat
//   ld_data     : merged, shifted and extended load result
module vscale_lsu_align
  import vscale_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned OFFW = $clog2(NB)
) (
  input  logic                beat,
  input  logic [OFFW-1:0]     off,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [XLEN-1:0]     wdata,
  input  logic [2*XLEN-1:0]   ld_buf,
  output logic [NB-1:0]       beat_be,
  output logic [XLEN-1:0]     beat_wdata,
  output logic [XLEN-1:0]     ld_data
);

  int unsigned       nbytes;
  logic [2*NB-1:0]   lane_mask;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wd_wide;
  logic [2*XLEN-1:0] ld_shift;
  logic [XLEN-1:0]   ld_raw;
  logic [XLEN-1:0]   ld_mask;
  logic              ld_sign;

  // Both beats are computed as halves of one double-width shift; the upper
  // half equals the right-shift-by-(NB-off) form used for the second beat.
  always_comb begin
    nbytes = 32'd1 << size;

    lane_mask = '0;
    for (int unsigned i = 0; i < 2 * NB; i++) lane_mask[i] = (i < nbytes);
    be_wide = lane_mask << off;
    wd_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

    beat_be    = beat ? be_wide[2*NB-1:NB]     : be_wide[NB-1:0];
    beat_wdata = beat ? wd_wide[2*XLEN-1:XLEN] : wd_wide[XLEN-1:0];

    ld_shift = ld_buf >> {off, 3'b000};
    ld_raw   = ld_shift[XLEN-1:0];
    ld_mask  = '0;
    ld_sign  = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      ld_mask[i] = (i < 8 * nbytes);
      if (i == 8 * nbytes - 1) ld_sign = ld_raw[i];
    end
    ld_data = (ld_raw & ld_mask) | ((ld_sign && !is_unsigned) ? ~ld_mask : '0);
  end

endmodule

// File: rtl/vscale_lsu.sv
// vscale load/store unit: one outstanding request between the execute stage
// and the data-memory port. Beat-crossing accesses are split into two
// aligned beats (SPLIT_MISALIGNED=1) or trapped without a bus access (=0).
//   req_*   : request handshake and fields from execute
//   resp_*  : one-cycle completion pulse with load data and error flags
//   dmem_*  : address phase (en/wen/addr/be) and data phase (wdata/wait/
//             rdata/badmem_e) of the data-memory bus
module vscale_lsu
  import vscale_lsu_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_badmem,
  output logic              dmem_en,
  output logic              dmem_wen,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_wait,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_badmem_e
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  state_e            state, state_nxt;
  logic              wen_q, uns_q, beat_q, err_q, mis_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [2*XLEN-1:0] cap_q;

  logic              accept, cross_req, cross_q, err_now, data_done;
  logic [XLEN-1:0]   beat_base;
  logic [NB-1:0]     beat_be;
  logic [XLEN-1:0]   beat_wdata, ld_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign cross_req = crosses_beat(32'(req_addr[OFFW-1:0]), req_size, NB);
  assign cross_q   = crosses_beat(32'(addr_q[OFFW-1:0]), size_q, NB);
  assign data_done = (state == DATA) && !dmem_wait;
  assign err_now   = err_q || dmem_badmem_e;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (cross_req && !SPLIT_MISALIGNED) ? RESP : ADDR;
      ADDR: state_nxt = DATA;
      DATA: if (!dmem_wait) state_nxt = (cross_q && !beat_q && !err_now) ? ADDR : RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        beat_q  <= 1'b0;
        err_q   <= 1'b0;
        mis_q   <= cross_req && !SPLIT_MISALIGNED;
        cap_q   <= '0;
      end
      if (data_done) begin
        if (beat_q) cap_q[2*XLEN-1:XLEN] <= dmem_rdata;
        else        cap_q[XLEN-1:0]      <= dmem_rdata;
        err_q <= err_now;
        if (state_nxt == ADDR) beat_q <= 1'b1;
      end
    end
  end

  vscale_lsu_align #(.XLEN(XLEN)) u_align (
    .beat        (beat_q),
    .off         (addr_q[OFFW-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .ld_buf      (cap_q),
    .beat_be     (beat_be),
    .beat_wdata  (beat_wdata),
    .ld_data     (ld_data)
  );

  assign beat_base = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} + (beat_q ? XLEN'(NB) : '0);

  // Bus and response outputs are gated by state so idle values are zero.
  assign dmem_en         = (state == ADDR);
  assign dmem_wen        = dmem_en && wen_q;
  assign dmem_addr       = dmem_en ? beat_base : '0;
  assign dmem_be         = dmem_en ? beat_be : '0;
  assign dmem_wdata      = ((state == DATA) && wen_q) ? beat_wdata : '0;

  assign resp_valid      = (state == RESP);
  assign resp_misaligned = resp_valid && mis_q;
  assign resp_badmem     = resp_valid && err_q;
  assign resp_rdata      = (resp_valid && !wen_q && !err_q && !mis_q) ? ld_data : '0;

  always_ff @(posedge clk) begin
    if (!reset && accept) assert (XLEN == 64 || req_size != SIZE_D);
  end

endmodule

// File: tb/tb_vscale_lsu.sv
module tb_vscale_lsu;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // split instance
  logic            req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]      req_size;
  logic [31:0]     req_addr, req_wdata;
  logic            resp_valid, resp_misaligned, resp_badmem;
  logic [31:0]     resp_rdata;
  logic            dmem_en, dmem_wen, dmem_wait, dmem_badmem_e;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;

  // trapping instance
  logic            t_req_valid, t_req_ready, t_req_wen, t_req_unsigned;
  logic [1:0]      t_req_size;
  logic [31:0]     t_req_addr, t_req_wdata;
  logic            t_resp_valid, t_resp_misaligned, t_resp_badmem;
  logic [31:0]     t_resp_rdata;
  logic            t_dmem_en, t_dmem_wen;
  logic [31:0]     t_dmem_addr, t_dmem_wdata;
  logic [3:0]      t_dmem_be;

  vscale_lsu #(.XLEN(XLEN), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_badmem(resp_badmem),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_wait(dmem_wait),
    .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e)
  );

  vscale_lsu #(.XLEN(XLEN), .SPLIT_MISALIGNED(1'b0)) dut_t (
    .clk(clk), .reset(reset),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_wen(t_req_wen),
    .req_size(t_req_size), .req_unsigned(t_req_unsigned), .req_addr(t_req_addr),
    .req_wdata(t_req_wdata), .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata),
    .resp_misaligned(t_resp_misaligned), .resp_badmem(t_resp_badmem),
    .dmem_en(t_dmem_en), .dmem_wen(t_dmem_wen), .dmem_addr(t_dmem_addr),
    .dmem_be(t_dmem_be), .dmem_wdata(t_dmem_wdata), .dmem_wait(1'b0),
    .dmem_rdata(32'h0), .dmem_badmem_e(1'b0)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wen;
    logic [31:0] wdata;
    int unsigned waits;
    logic [31:0] rdata;
    logic        bad;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        bad;
    int unsigned lat;
  } resp_t;

  beat_t       beat_exp_q[$];
  resp_t       resp_exp_q[$];
  beat_t       rb;
  resp_t       rr;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned resp_seen = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic void push_beat(input logic [31:0] addr, input logic [3:0] be,
                                    input logic wen, input logic [31:0] wdata,
                                    input int unsigned waits, input logic [31:0] rdata,
                                    input logic bad);
    beat_t b;
    b.addr = addr; b.be = be; b.wen = wen; b.wdata = wdata;
    b.waits = waits; b.rdata = rdata; b.bad = bad;
    beat_exp_q.push_back(b);
  endfunction

  function automatic void push_resp(input logic [31:0] rdata, input logic mis,
                                    input logic bad, input int unsigned lat);
    resp_t r;
    r.rdata = rdata; r.mis = mis; r.bad = bad; r.lat = lat;
    resp_exp_q.push_back(r);
  endfunction

  // memory responder: checks each address phase against the expected beat
  initial begin
    dmem_wait = 1'b0; dmem_rdata = '0; dmem_badmem_e = 1'b0;
    forever begin
      @(negedge clk);
      if (dmem_en === 1'b1) begin
        if (beat_exp_q.size() == 0) begin
          check("dmem_en_unexpected", 32'(1), 32'(0));
        end else begin
          rb = beat_exp_q.pop_front();
          check("beat_addr", dmem_addr, rb.addr);
          check("beat_be", 32'(dmem_be), 32'(rb.be));
          check("beat_wen", 32'(dmem_wen), 32'(rb.wen));
          dmem_wait     = (rb.waits != 0);
          dmem_rdata    = rb.rdata;
          dmem_badmem_e = rb.bad;
          for (int unsigned j = 0; j <= rb.waits; j++) begin
            @(negedge clk);
            check("data_wdata", dmem_wdata, rb.wdata);
            check("data_en_low", 32'(dmem_en), 32'(0));
            if (j == rb.waits) dmem_wait = 1'b0;
          end
        end
      end else begin
        dmem_wait = 1'b0; dmem_rdata = '0; dmem_badmem_e = 1'b0;
      end
    end
  end

  // response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (resp_exp_q.size() == 0) begin
          check("resp_unexpected", 32'(1), 32'(0));
        end else begin
          rr = resp_exp_q.pop_front();
          check("resp_rdata", resp_rdata, rr.rdata);
          check("resp_misaligned", 32'(resp_misaligned), 32'(rr.mis));
          check("resp_badmem", 32'(resp_badmem), 32'(rr.bad));
          check("resp_latency", 32'(cyc - acc_cyc), 32'(rr.lat));
        end
        resp_seen++;
      end
    end
  end

  task automatic run_req(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned seen0;
    @(negedge clk);
    seen0 = resp_seen;
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    acc_cyc = cyc;
    check("req_ready_idle", 32'(req_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (resp_seen != seen0) break;
      @(negedge clk);
    end
    check("resp_arrived", 32'(resp_seen != seen0), 32'(1));
    @(negedge clk);
    check("beats_consumed", 32'(beat_exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    t_req_valid = 0; t_req_wen = 0; t_req_size = 0; t_req_unsigned = 0; t_req_addr = 0; t_req_wdata = 0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_dmem_en", 32'(dmem_en), 32'(0));
    check("rst_dmem_wen", 32'(dmem_wen), 32'(0));
    check("rst_dmem_addr", dmem_addr, 32'(0));
    check("rst_dmem_be", 32'(dmem_be), 32'(0));
    check("rst_dmem_wdata", dmem_wdata, 32'(0));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_resp_flags", 32'({resp_misaligned, resp_badmem}), 32'(0));
    check("rst_resp_rdata", resp_rdata, 32'(0));
    check("rst_t_req_ready", 32'(t_req_ready), 32'(1));
    reset = 1'b0;

    // LW aligned
    push_beat(32'h100, 4'b1111, 0, 32'h0, 0, 32'hDEADBEEF, 0);
    push_resp(32'hDEADBEEF, 0, 0, 3);
    run_req(0, 2'd2, 0, 32'h100, 32'h0);

    // LB / LBU top lane
    push_beat(32'h100, 4'b1000, 0, 32'h0, 0, 32'h80123456, 0);
    push_resp(32'hFFFFFF80, 0, 0, 3);
    run_req(0, 2'd0, 0, 32'h103, 32'h0);
    push_beat(32'h100, 4'b1000, 0, 32'h0, 0, 32'h80123456, 0);
    push_resp(32'h00000080, 0, 0, 3);
    run_req(0, 2'd0, 1, 32'h103, 32'h0);

    // SH misaligned within one beat
    push_beat(32'h100, 4'b0110, 1, 32'h00ABCD00, 0, 32'h0, 0);
    push_resp(32'h0, 0, 0, 3);
    run_req(1, 2'd1, 0, 32'h101, 32'h0000ABCD);

    // LH upper half, sign-extended
    push_beat(32'h100, 4'b1100, 0, 32'h0, 0, 32'h80010000, 0);
    push_resp(32'hFFFF8001, 0, 0, 3);
    run_req(0, 2'd1, 0, 32'h102, 32'h0);

    // LW crossing, 2 wait cycles on beat 0
    push_beat(32'h100, 4'b1100, 0, 32'h0, 2, 32'h11223344, 0);
    push_beat(32'h104, 4'b0011, 0, 32'h0, 0, 32'h55667788, 0);
    push_resp(32'h77881122, 0, 0, 7);
    run_req(0, 2'd2, 0, 32'h102, 32'h0);

    // SW crossing, 1 wait cycle on beat 1
    push_beat(32'h100, 4'b1100, 1, 32'hCCDD0000, 0, 32'h0, 0);
    push_beat(32'h104, 4'b0011, 1, 32'h0000AABB, 1, 32'h0, 0);
    push_resp(32'h0, 0, 0, 6);
    run_req(1, 2'd2, 0, 32'h102, 32'hAABBCCDD);

    // LHU crossing at the last byte
    push_beat(32'h000, 4'b1000, 0, 32'h0, 0, 32'hAB000000, 0);
    push_beat(32'h004, 4'b0001, 0, 32'h0, 0, 32'h000000CD, 0);
    push_resp(32'h0000CDAB, 0, 0, 5);
    run_req(0, 2'd1, 1, 32'h003, 32'h0);

    // bus error on beat 0 of a crossing load: no second beat
    push_beat(32'h100, 4'b1100, 0, 32'h0, 0, 32'h12345678, 1);
    push_resp(32'h0, 0, 1, 3);
    run_req(0, 2'd2, 0, 32'h102, 32'h0);

    // trapping instance: SW crossing
    @(negedge clk);
    t_req_valid = 1; t_req_wen = 1; t_req_size = 2'd2; t_req_addr = 32'h0FE; t_req_wdata = 32'h1234;
    check("trap_ready", 32'(t_req_ready), 32'(1));
    check("trap_en_c0", 32'(t_dmem_en), 32'(0));
    @(posedge clk);
    @(negedge clk);
    t_req_valid = 0;
    check("trap_resp_valid", 32'(t_resp_valid), 32'(1));
    check("trap_misaligned", 32'(t_resp_misaligned), 32'(1));
    check("trap_badmem", 32'(t_resp_badmem), 32'(0));
    check("trap_en_c1", 32'(t_dmem_en), 32'(0));
    @(negedge clk);
    check("trap_resp_done", 32'(t_resp_valid), 32'(0));
    check("trap_ready_again", 32'(t_req_ready), 32'(1));

    // reset during DATA abandons the request
    push_beat(32'h200, 4'b1111, 0, 32'h0, 0, 32'hCAFEF00D, 0);
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h200; req_wdata = 0;
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstdata_en", 32'(dmem_en), 32'(0));
    check("rstdata_ready", 32'(req_ready), 32'(1));
    check("rstdata_resp", 32'(resp_valid), 32'(0));
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rstdata_beats", 32'(beat_exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vscale_lsu.md
# vscale_lsu

Parametrised load/store unit between the vscale execute stage and the data-memory port. It accepts one memory request at a time and generates byte enables and lane-aligned store data. It merges and sign- or zero-extends load data, and reports bus errors. Unlike the fixed 32-bit memory path, it supports XLEN of 32 or 64 and handles beat-crossing misaligned accesses in one of two modes: split into two aligned bus beats, or trap.

## Interface

Parameters:
- XLEN, 32, data/address width; 32 or 64 only.
- SPLIT_MISALIGNED, 1, 1 = split beat-crossing accesses into two beats; 0 = report them as misaligned with no bus access.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, accepts request.
- req_wen  in  1  1 = store.
- req_size  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D (D legal only when XLEN=64).
- req_unsigned  in  1  zero-extend load.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores.
- resp_misaligned  out  1  beat-crossing access trapped (SPLIT_MISALIGNED=0 only).
- resp_badmem  out  1  bus error on any beat.
- dmem_en  out  1  address-phase valid.
- dmem_wen  out  1  address-phase write.
- dmem_addr  out  XLEN  beat-aligned address.
- dmem_be  out  XLEN/8  byte enables.
- dmem_wdata  out  XLEN  store data, driven in the data phase.
- dmem_wait  in  1  extends the current data phase.
- dmem_rdata  in  XLEN  load data, valid at the end of the data phase.
- dmem_badmem_e  in  1  error, sampled with the data phase.

## Operation

**Request handling**
- Request is accepted on req_valid & req_ready.
- All request fields are registered on acceptance.
- Only one request is outstanding at a time.

**Address arithmetic** (NB = XLEN/8)
- off = addr mod NB.
- n = 1 << size.
- A request crosses a beat when off + n > NB.
- A request that is misaligned but stays within one beat (e.g. LH at offset 1) is a normal single beat in both modes.

**Beat 0**
- Address: addr with the low log2(NB) bits cleared.
- Byte enables: ((1<<n)-1) << off, truncated to NB bits.
- Write data: wdata << 8·off.

**Beat 1** (crossing only)
- Address: beat-0 address + NB.
- Byte enables: ((1<<n)-1) >> (NB-off).
- Write data: wdata >> 8·(NB-off).

**Load merge**
- Both beats are concatenated as {beat1, beat0}.
- The result is shifted right by 8·off and masked to n bytes.
- It is then sign-extended from bit 8n-1 unless req_unsigned is set.

**State machine**
- IDLE → ADDR on accept, or → RESP directly if the access crosses a beat and SPLIT_MISALIGNED=0.
- ADDR drives one cycle of dmem_en, dmem_wen, dmem_addr and dmem_be for the current beat, then → DATA.
- DATA holds while dmem_wait=1. When dmem_wait=0, rdata and error are captured, then:
  - → ADDR for beat 1 if crossing and no error so far;
  - otherwise → RESP.
- RESP pulses resp_valid with the final data and flags, then → IDLE.

**Errors**
- dmem_badmem_e on beat 0 skips beat 1.
- In that case resp_badmem=1 and resp_rdata=0.

**Electrical rules**
- dmem_en=0 in every state except ADDR.
- dmem_wdata is held stable throughout DATA.

## Timing

- Accept at cycle 0.
- Single beat, no wait: ADDR in cycle 1, DATA in cycle 2, resp_valid in cycle 3.
- Split: ADDR/DATA in cycles 1–2 and 3–4, resp_valid in cycle 5.
- Each wait cycle adds one cycle.
- Trap (SPLIT_MISALIGNED=0): resp_valid in cycle 1, no dmem_en.
- req_ready is high only in IDLE, so the earliest next accept is the cycle after resp_valid.
- resp_valid has no back-pressure.
- Reset values: req_ready=1; dmem_en, dmem_wen, resp_valid, resp_misaligned and resp_badmem = 0; dmem_be, dmem_addr, dmem_wdata and resp_rdata = 0.
- Reset mid-operation:
  - the state returns to IDLE on the next edge;
  - the pending request is abandoned, with no resp_valid;
  - if reset is asserted during DATA, the bus data phase is dropped.
- req_size=3 with XLEN=32 is illegal and is covered by a simulation assertion.

## Structure

- Shared package vscale_lsu_pkg holds:
  - the size encodings (B/H/W/D);
  - the state encoding (IDLE/ADDR/DATA/RESP);
  - the helper for the crossing predicate.
- Sub-module vscale_lsu_align is purely combinational. It computes beat byte enables and beat write data for a given beat index, and performs the load merge/extend.
- The top level holds the FSM, the request registers, the beat index and the 2×XLEN capture buffer.

## Test plan

All scenarios use XLEN=32.
1. LW 0x100, rdata 0xDEADBEEF → beat addr 0x100, be 4'b1111, resp_valid at cycle 3, resp_rdata 0xDEADBEEF.
2. LB 0x103, rdata 0x80123456 → be 4'b1000, resp_rdata 0xFFFFFF80; the same access as LBU → 0x00000080.
3. SH 0x101, wdata 0xABCD → single beat, be 4'b0110, dmem_wdata 0x00ABCD00 in DATA, resp_misaligned=0.
4. SPLIT=1, LW 0x102, beat0 rdata 0x11223344 with 2 wait cycles, beat1 rdata 0x55667788:
   - beat addresses 0x100 (be 1100) and 0x104 (be 0011);
   - resp_rdata 0x77881122 at cycle 7.
5. SPLIT=0, SW 0x0FE → no dmem_en; resp_valid at cycle 1 with resp_misaligned=1.
6. SPLIT=1, LW 0x102 with badmem on beat0 → no second dmem_en, resp_badmem=1. Separately, reset asserted in DATA → dmem_en=0 and req_ready=1 the next cycle, and no resp_valid.
